// File: rtl/abz_pkg.sv
// Shared A/B/Z definitions: widths, default filter length and the quadrature
// transition tables also used by the A/B/Z pulse generator.
package abz_pkg;

    localparam int unsigned POS_W        = 16;
    localparam int unsigned FILT_LEN_DEF = 3;

    // Next {A,B} for a forward step (A leads B), indexed by current {A,B}:
    // 00->10, 01->00, 10->11, 11->01.
    localparam logic [1:0] AB_FWD_NEXT [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    // Next {A,B} for a reverse step (B leads A), indexed by current {A,B}.
    localparam logic [1:0] AB_REV_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_e;

    // Classify a filtered {A,B} transition.
    function automatic step_e ab_classify(input logic [1:0] prev, input logic [1:0] cur);
        step_e s;
        if (prev == cur)                  s = STEP_NONE;
        else if ((prev ^ cur) == 2'b11)   s = STEP_ERR;
        else if (cur == AB_FWD_NEXT[prev]) s = STEP_FWD;
        else                              s = STEP_REV;
        return s;
    endfunction

endpackage

// File: rtl/abz_in_filter.sv
// 2-FF synchroniser followed by a glitch filter: a level change is accepted
// only after FILT_LEN consecutive identical synchronised samples.
module abz_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk_in,
    input  logic sys_rst,
    input  logic d_in,
    output logic d_filt
);

    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          s1_q, s2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    // Filter next state: restart the run count whenever s2 agrees with the output.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == CW'(FILT_LEN - 1)) begin
            filt_d = s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + CW'(1);
        end
    end

    // Synchroniser and filter registers.
    always_ff @(posedge clk_in or negedge sys_rst) begin
        if (!sys_rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            s1_q   <= d_in;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign d_filt = filt_q;

endmodule

// File: rtl/abz_quad_decoder.sv
// Quadrature A/B/Z decoder: filtered inputs, x4 position counter, Z position
// latch and A rising-edge period measurement.
module abz_quad_decoder
    import abz_pkg::*;
#(
    parameter int unsigned FILT_LEN = FILT_LEN_DEF,
    parameter bit          Z_CLR    = 1'b0
) (
    input  logic             clk_in,
    input  logic             sys_rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             z_in,
    input  logic             dec_en,
    input  logic             cnt_clr,
    output logic [POS_W-1:0] pos_cnt,
    output logic             dir,
    output logic [POS_W-1:0] z_pos,
    output logic             z_valid,
    output logic [POS_W-1:0] edge_period,
    output logic             period_valid,
    output logic             err_flag
);

    logic a_f, b_f, z_f;

    abz_in_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk_in(clk_in), .sys_rst(sys_rst), .d_in(a_in), .d_filt(a_f));
    abz_in_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk_in(clk_in), .sys_rst(sys_rst), .d_in(b_in), .d_filt(b_f));
    abz_in_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (.clk_in(clk_in), .sys_rst(sys_rst), .d_in(z_in), .d_filt(z_f));

    logic [1:0]       ab_q, ab_d;
    logic             zp_q, zp_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] zpos_q, zpos_d;
    logic             zval_q, zval_d;
    logic [POS_W-1:0] per_q, per_d;
    logic [POS_W-1:0] eper_q, eper_d;
    logic             pval_q, pval_d;
    logic             err_q, err_d;
    logic             flag_q, flag_d;

    step_e step;
    logic  a_rise, z_rise;

    assign step   = ab_classify(ab_q, {a_f, b_f});
    assign a_rise = a_f & ~ab_q[1];
    assign z_rise = z_f & ~zp_q;

    // Next-state logic: clear beats disable beats normal decoding.
    // Previous A/B/Z tracking always follows the filters so re-enable sees no false step.
    always_comb begin
        ab_d   = {a_f, b_f};
        zp_d   = z_f;
        pos_d  = pos_q;
        dir_d  = dir_q;
        zpos_d = zpos_q;
        zval_d = 1'b0;
        per_d  = per_q;
        eper_d = eper_q;
        pval_d = 1'b0;
        err_d  = err_q;
        flag_d = flag_q;
        if (cnt_clr) begin
            pos_d  = '0;
            zpos_d = '0;
            per_d  = '0;
            err_d  = 1'b0;
            flag_d = 1'b0;
        end else if (!dec_en) begin
            per_d  = '0;
            flag_d = 1'b0;
        end else begin
            case (step)
                STEP_FWD: begin
                    pos_d = pos_q + POS_W'(1);
                    dir_d = 1'b1;
                end
                STEP_REV: begin
                    pos_d = pos_q - POS_W'(1);
                    dir_d = 1'b0;
                end
                STEP_ERR: err_d = 1'b1;
                default:  ;
            endcase
            // Z captures the pre-step count; with Z_CLR the clear wins over the step.
            if (z_rise) begin
                zpos_d = pos_q;
                zval_d = 1'b1;
                if (Z_CLR) pos_d = '0;
            end
            if (per_q != '1) per_d = per_q + POS_W'(1);
            if (a_rise) begin
                per_d = POS_W'(1);
                if (flag_q) begin
                    eper_d = per_q;
                    pval_d = 1'b1;
                end
                flag_d = 1'b1;
            end
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk_in or negedge sys_rst) begin
        if (!sys_rst) begin
            ab_q   <= '0;
            zp_q   <= 1'b0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            zpos_q <= '0;
            zval_q <= 1'b0;
            per_q  <= '0;
            eper_q <= '0;
            pval_q <= 1'b0;
            err_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            ab_q   <= ab_d;
            zp_q   <= zp_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            zpos_q <= zpos_d;
            zval_q <= zval_d;
            per_q  <= per_d;
            eper_q <= eper_d;
            pval_q <= pval_d;
            err_q  <= err_d;
            flag_q <= flag_d;
        end
    end

    assign pos_cnt      = pos_q;
    assign dir          = dir_q;
    assign z_pos        = zpos_q;
    assign z_valid      = zval_q;
    assign edge_period  = eper_q;
    assign period_valid = pval_q;
    assign err_flag     = err_q;

endmodule

// File: tb/tb_abz_quad_decoder.sv
// Directed bench for abz_quad_decoder: generator-style A/B waveforms, glitch
// filtering, wrap, Z latching (with and without Z_CLR), errors and reset.
module tb_abz_quad_decoder;

    logic        clk_in = 1'b0;
    logic        sys_rst, a_in, b_in, z_in, dec_en, cnt_clr;
    logic [15:0] pos_cnt, z_pos, edge_period;
    logic        dir, z_valid, period_valid, err_flag;
    logic [15:0] pos_cnt_zc, z_pos_zc, edge_period_zc;
    logic        dir_zc, z_valid_zc, period_valid_zc, err_flag_zc;

    int n_tests = 0;
    int n_fail  = 0;
    int pv_n    = 0;
    int zv_n    = 0;
    int unsigned ab_phase = 0;

    abz_quad_decoder #(.FILT_LEN(3), .Z_CLR(1'b0)) dut (
        .clk_in(clk_in), .sys_rst(sys_rst), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .dec_en(dec_en), .cnt_clr(cnt_clr), .pos_cnt(pos_cnt), .dir(dir), .z_pos(z_pos),
        .z_valid(z_valid), .edge_period(edge_period), .period_valid(period_valid),
        .err_flag(err_flag)
    );

    abz_quad_decoder #(.FILT_LEN(3), .Z_CLR(1'b1)) dut_zc (
        .clk_in(clk_in), .sys_rst(sys_rst), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .dec_en(dec_en), .cnt_clr(cnt_clr), .pos_cnt(pos_cnt_zc), .dir(dir_zc), .z_pos(z_pos_zc),
        .z_valid(z_valid_zc), .edge_period(edge_period_zc), .period_valid(period_valid_zc),
        .err_flag(err_flag_zc)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters, sampled on the inactive edge.
    always @(negedge clk_in) begin
        if (period_valid) pv_n++;
        if (z_valid) zv_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Quadrature phase 0..3 maps to {A,B} = 00,10,11,01.
    task automatic drive_ab();
        a_in = (ab_phase == 1) || (ab_phase == 2);
        b_in = (ab_phase >= 2);
    endtask

    // n quarter-steps of 10 cycles each; a full A period is 40 cycles.
    task automatic step(input bit fwd, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ab_phase = fwd ? (ab_phase + 1) % 4 : (ab_phase + 3) % 4;
            drive_ab();
            tick(10);
        end
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b0; a_in = 1'b0; b_in = 1'b0; z_in = 1'b0;
        dec_en = 1'b1; cnt_clr = 1'b0;
        tick(3);
        check("rst_pos", 32'(pos_cnt), 32'h0);
        check("rst_zpos_per", {z_pos, edge_period}, 32'h0);
        check("rst_flags", {28'h0, dir, z_valid, period_valid, err_flag}, 32'h0);
        sys_rst = 1'b1;
        tick(2);

        // 1: 10 forward generator periods
        pv_n = 0;
        step(1'b1, 40);
        tick(10);
        check("fwd_pos", 32'(pos_cnt), 32'd40);
        check("fwd_dir", 32'(dir), 32'd1);
        check("fwd_period", 32'(edge_period), 32'd40);
        check("fwd_pv_count", 32'(pv_n), 32'd9);
        check("fwd_err", 32'(err_flag), 32'd0);

        // 2: 10 reverse periods from cleared count
        pulse_clr();
        check("clr_pos", 32'(pos_cnt), 32'd0);
        step(1'b0, 40);
        check("rev_pos", 32'(pos_cnt), 32'h0000FFD8);
        check("rev_dir", 32'(dir), 32'd0);
        check("rev_period", 32'(edge_period), 32'd40);

        // 3: wrap in both directions
        pulse_clr();
        step(1'b0, 1);
        check("wrap_dn", 32'(pos_cnt), 32'h0000FFFF);
        step(1'b1, 1);
        check("wrap_up", 32'(pos_cnt), 32'd0);
        check("wrap_up_dir", 32'(dir), 32'd1);

        // 4: glitch rejection and filter latency (AB = 00 here)
        a_in = 1'b1;
        tick(2);
        a_in = 1'b0;
        tick(10);
        check("glitch2_pos", 32'(pos_cnt), 32'd0);
        a_in = 1'b1;
        tick(3);
        a_in = 1'b0;
        tick(2);
        check("pulse3_pre_rise", 32'(pos_cnt), 32'd0);
        tick(1);
        check("pulse3_rise", 32'(pos_cnt), 32'd1);
        tick(2);
        check("pulse3_pre_fall", 32'(pos_cnt), 32'd1);
        tick(1);
        check("pulse3_fall", 32'(pos_cnt), 32'd0);
        check("pulse3_fall_dir", 32'(dir), 32'd0);
        tick(5);

        // 5: Z latch at pos 25
        step(1'b1, 25);
        check("z_pre_pos", 32'(pos_cnt), 32'd25);
        check("z_pre_pos_zc", 32'(pos_cnt_zc), 32'd25);
        zv_n = 0;
        z_in = 1'b1;
        tick(30);
        z_in = 1'b0;
        tick(10);
        check("z_pos", 32'(z_pos), 32'd25);
        check("z_valid_count", 32'(zv_n), 32'd1);
        check("z_pos_held", 32'(pos_cnt), 32'd25);
        check("zc_pos_cleared", 32'(pos_cnt_zc), 32'd0);
        check("zc_z_pos", 32'(z_pos_zc), 32'd25);

        // 6: illegal double change, then clear (phase 1 = AB 10 -> 01)
        ab_phase = 3;
        drive_ab();
        tick(10);
        check("err_set", 32'(err_flag), 32'd1);
        check("err_pos_hold", 32'(pos_cnt), 32'd25);
        pulse_clr();
        check("err_clr", 32'(err_flag), 32'd0);
        check("err_clr_pos", 32'(pos_cnt), 32'd0);

        // dec_en low freezes; re-enable gives no false step
        dec_en = 1'b0;
        step(1'b1, 1);
        check("dis_pos_hold", 32'(pos_cnt), 32'd0);
        dec_en = 1'b1;
        tick(10);
        check("reen_no_step", 32'(pos_cnt), 32'd0);
        step(1'b1, 1);
        check("reen_step", 32'(pos_cnt), 32'd1);

        // asynchronous reset mid-count
        step(1'b1, 3);
        check("mid_pos", 32'(pos_cnt), 32'd4);
        ab_phase = 1;
        drive_ab();
        tick(3);
        #2;
        sys_rst = 1'b0;
        #1;
        check("arst_pos", 32'(pos_cnt), 32'd0);
        check("arst_zpos_per", {z_pos, edge_period}, 32'h0);
        check("arst_flags", {28'h0, dir, z_valid, period_valid, err_flag}, 32'h0);
        tick(8);
        check("arst_hold_pos", 32'(pos_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
